regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter between pipeline (A) and long-latency unit (B) with a busy scoreboard.
// Latency: accepted write appears on WriteReg/DstReg/DstData one cycle later. Backpressure: ready only to the
// granted requester; A stalls while its destination is busy. Macro REGARB_FIXED_PRIO_EN: A always wins ties.
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a_valid,
    input  logic [3:0]  req_a_reg,
    input  logic [15:0] req_a_data,
    output logic        req_a_ready,
    input  logic        req_b_valid,
    input  logic [3:0]  req_b_reg,
    input  logic [15:0] req_b_data,
    output logic        req_b_ready,
    input  logic        issue_valid,
    input  logic [3:0]  issue_reg,
    output logic        issue_ready,
    input  logic [3:0]  SrcReg1,
    input  logic [3:0]  SrcReg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData
);

    logic [15:0] busy;
    logic [15:0] busy_next;
    logic        a_elig;
    logic        b_elig;
    logic        grant_a;
    logic        grant_b;
    logic        issue_fire;

    assign a_elig = req_a_valid & ~busy[req_a_reg];
    assign b_elig = req_b_valid;

`ifdef REGARB_FIXED_PRIO_EN
    assign grant_a = a_elig;
`else
    // last_grant_b=1 means B won most recently, so A wins the next tie.
    logic last_grant_b;

    assign grant_a = a_elig & (~b_elig | last_grant_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_b <= 1'b1;
        end else if (grant_a) begin
            last_grant_b <= 1'b0;
        end else if (grant_b) begin
            last_grant_b <= 1'b1;
        end
    end
`endif

    assign grant_b     = b_elig & ~grant_a;
    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;

    assign issue_ready = ~busy[issue_reg];
    assign issue_fire  = issue_valid & issue_ready;

    // In-flight writes are covered by the register-file bypass, so hazards see only the scoreboard.
    assign hazard1 = busy[SrcReg1];
    assign hazard2 = busy[SrcReg2];

    // Set is applied after clear so a same-edge issue to the register B is retiring wins.
    always_comb begin
        busy_next = busy;
        if (grant_b) begin
            busy_next[req_b_reg] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 16'h0000;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WriteReg <= 1'b0;
            DstReg   <= 4'h0;
            DstData  <= 16'h0000;
        end else begin
            WriteReg <= grant_a | grant_b;
            if (grant_a) begin
                DstReg  <= req_a_reg;
                DstData <= req_a_data;
            end else if (grant_b) begin
                DstReg  <= req_b_reg;
                DstData <= req_b_data;
            end
        end
    end

endmodule
